mac_learn_writer: RTL and testbench

MAC_LEARN_WRITER -- requirements
Module: mac_learn_writer

---
 rtl/mac_learn_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_mac_learn_writer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mac_learn_writer.sv
// Learns source MAC addresses into a direct-mapped table indexed by an XOR fold of the address.
// Optional feature macro AGING_EN enables the background aging sweep; without it o_aged is tied low.
module mac_learn_writer #(
    parameter int pMAX_PORT_NUMBER = 8,
    parameter int pADRESS          = 3,
    parameter int pTABLE_AW        = 8,
    parameter int pAGE_TICK        = 1024
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               i_write_en,
    input  logic [pADRESS-1:0] i_port_num,
    input  logic [47:0]        i_SA,
    output logic               o_ready,
    output logic               o_done,
    output logic [pADRESS-1:0] o_done_port,
    output logic               o_new_entry,
    output logic               o_collision,
    output logic               o_overrun,
    output logic               o_aged
);
    localparam int LP_DEPTH  = 1 << pTABLE_AW;
    localparam int LP_NCHUNK = (48 + pTABLE_AW - 1) / pTABLE_AW;
    localparam int LP_PADW   = LP_NCHUNK * pTABLE_AW;
    localparam int LP_EW     = 48 + pADRESS;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CMP, ST_WRITE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;

    logic [LP_PADW-1:0]   w_sa_pad;
    logic [pTABLE_AW-1:0] w_chunk [LP_NCHUNK];
    logic [pTABLE_AW-1:0] w_idx;

    logic [47:0]          r_sa;
    logic [pADRESS-1:0]   r_port;
    logic [pTABLE_AW-1:0] r_idx;
    logic [LP_EW-1:0]     r_rd_entry;
    logic                 r_do_write;

    logic                 r_done;
    logic                 r_collision;
    logic                 r_overrun;
    logic                 r_new_entry;
    logic [pADRESS-1:0]   r_done_port;

    logic [LP_DEPTH-1:0]  r_valid;
    logic [LP_DEPTH-1:0]  r_age;
    logic [LP_EW-1:0]     r_mem [LP_DEPTH];

    logic                 w_entry_valid;
    logic                 w_mac_eq;
    logic                 w_collision;
    logic                 w_commit;

    // Index hash: XOR of pTABLE_AW-bit chunks of the zero-extended address.
    always_comb begin
        w_sa_pad       = '0;
        w_sa_pad[47:0] = i_SA;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LP_NCHUNK; gi++) begin : g_fold
            assign w_chunk[gi] = w_sa_pad[gi*pTABLE_AW +: pTABLE_AW];
        end
    endgenerate

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < LP_NCHUNK; k++) begin
            w_idx = w_idx ^ w_chunk[k];
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        o_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_write_en) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ:  w_state_next = ST_CMP;
            ST_CMP:   w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_entry_valid = r_valid[r_idx];
    assign w_mac_eq      = (r_rd_entry[pADRESS +: 48] == r_sa);
    assign w_collision   = w_entry_valid & ~w_mac_eq;
    assign w_commit      = (r_state == ST_WRITE) & r_do_write;

    // Request capture and result registers; results stay put until the next decision.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_sa        <= '0;
            r_port      <= '0;
            r_idx       <= '0;
            r_do_write  <= 1'b0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
            r_overrun   <= 1'b0;
            r_new_entry <= 1'b0;
            r_done_port <= '0;
        end else begin
            r_done      <= 1'b0;
            r_collision <= 1'b0;
            r_overrun   <= i_write_en & ~o_ready;
            if (w_accept) begin
                r_sa   <= i_SA;
                r_port <= i_port_num;
                r_idx  <= w_idx;
            end
            if (r_state == ST_CMP) begin
                r_done      <= 1'b1;
                r_collision <= w_collision;
                r_new_entry <= ~w_entry_valid;
                r_done_port <= r_port;
                r_do_write  <= ~w_collision;
            end
        end
    end

    // MAC/port storage carries no reset; the valid bits alone gate its meaning.
    always_ff @(posedge iclk) begin
        if (w_commit) begin
            r_mem[r_idx] <= {r_sa, r_port};
        end
        if (r_state == ST_READ) begin
            r_rd_entry <= r_mem[r_idx];
        end
    end

`ifdef AGING_EN
    localparam int LP_PW = (pAGE_TICK > 1) ? $clog2(pAGE_TICK) : 1;

    logic [LP_PW-1:0]     r_presc;
    logic [pTABLE_AW-1:0] r_age_ptr;
    logic                 r_age_pending;
    logic                 r_aged;
    logic                 w_tick;
    logic                 w_age_step;

    assign w_tick     = (r_presc == LP_PW'(pAGE_TICK - 1));
    // Aging never competes with a request: it runs only in an idle cycle with no new request.
    assign w_age_step = r_age_pending & (r_state == ST_IDLE) & ~i_write_en;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_presc       <= '0;
            r_age_pending <= 1'b0;
            r_age_ptr     <= '0;
        end else begin
            r_presc       <= w_tick ? '0 : r_presc + 1'b1;
            r_age_pending <= w_tick | (r_age_pending & ~w_age_step);
            if (w_age_step) begin
                r_age_ptr <= r_age_ptr + 1'b1;
            end
        end
    end

    assign o_aged = r_aged;
`else
    assign o_aged = 1'b0;
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_valid <= '0;
            r_age   <= '0;
`ifdef AGING_EN
            r_aged  <= 1'b0;
`endif
        end else begin
`ifdef AGING_EN
            r_aged <= 1'b0;
            if (w_age_step) begin
                if (r_valid[r_age_ptr] && r_age[r_age_ptr]) begin
                    r_valid[r_age_ptr] <= 1'b0;
                    r_aged             <= 1'b1;
                end else begin
                    r_age[r_age_ptr] <= 1'b1;
                end
            end
`endif
            if (w_commit) begin
                r_valid[r_idx] <= 1'b1;
                r_age[r_idx]   <= 1'b0;
            end
        end
    end

    assign o_done      = r_done;
    assign o_done_port = r_done_port;
    assign o_new_entry = r_new_entry;
    assign o_collision = r_collision;
    assign o_overrun   = r_overrun;

    // The stored port belongs to the lookup path; this block only compares the MAC.
    logic w_unused;
`ifdef AGING_EN
    assign w_unused = ^{32'(pMAX_PORT_NUMBER), r_rd_entry[pADRESS-1:0]};
`else
    assign w_unused = ^{32'(pMAX_PORT_NUMBER), 32'(pAGE_TICK), r_rd_entry[pADRESS-1:0], r_age};
`endif

endmodule

// File: tb/tb_mac_learn_writer.sv
// Directed bench for mac_learn_writer: learn/refresh/collision/overrun/reset-abort, plus aging when AGING_EN is set.
module tb_mac_learn_writer;
    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        i_write_en = 1'b0;
    logic [2:0]  i_port_num = '0;
    logic [47:0] i_SA = '0;
    logic        o_ready, o_done, o_new_entry, o_collision, o_overrun, o_aged;
    logic [2:0]  o_done_port;

    int n_checks = 0;
    int n_errors = 0;

    always #5 iclk = ~iclk;

    mac_learn_writer #(
        .pMAX_PORT_NUMBER(8),
        .pADRESS(3),
        .pTABLE_AW(8),
        .pAGE_TICK(4)
    ) dut (
        .iclk(iclk),
        .irst(irst),
        .i_write_en(i_write_en),
        .i_port_num(i_port_num),
        .i_SA(i_SA),
        .o_ready(o_ready),
        .o_done(o_done),
        .o_done_port(o_done_port),
        .o_new_entry(o_new_entry),
        .o_collision(o_collision),
        .o_overrun(o_overrun),
        .o_aged(o_aged)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        irst = 1'b1;
        i_write_en = 1'b0;
        tick();
        tick();
        irst = 1'b0;
    endtask

    // One learn request; expects o_done exactly 3 cycles after acceptance.
    task automatic learn(input string tag, input logic [47:0] sa, input logic [2:0] port,
                         input logic exp_new, input logic exp_coll);
        int   lat;
        logic got_new, got_coll;
        logic [2:0] got_port;
        lat = 0; got_new = 1'b0; got_coll = 1'b0; got_port = '0;
        check_eq({tag, ".ready"}, 64'(o_ready), 64'd1);
        i_SA = sa; i_port_num = port; i_write_en = 1'b1;
        tick();
        i_write_en = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (o_done) begin
                lat = c; got_new = o_new_entry; got_coll = o_collision; got_port = o_done_port;
                break;
            end
            tick();
        end
        check_eq({tag, ".latency"}, 64'(lat), 64'd3);
        check_eq({tag, ".new_entry"}, 64'(got_new), 64'(exp_new));
        check_eq({tag, ".collision"}, 64'(got_coll), 64'(exp_coll));
        check_eq({tag, ".done_port"}, 64'(got_port), 64'(port));
        $display("txn %s: SA=%012h port=%0d latency=%0d new=%0b coll=%0b", tag, sa, port, lat, got_new, got_coll);
        tick();
        check_eq({tag, ".done_pulse"}, 64'(o_done), 64'd0);
        check_eq({tag, ".port_hold"}, 64'(o_done_port), 64'(port));
        check_eq({tag, ".new_hold"}, 64'(o_new_entry), 64'(exp_new));
    endtask

    initial begin
        int   cnt;
        int   first;
        // reset state
        tick();
        check_eq("rst.ready", 64'(o_ready), 64'd1);
        check_eq("rst.done", 64'(o_done), 64'd0);
        check_eq("rst.collision", 64'(o_collision), 64'd0);
        check_eq("rst.overrun", 64'(o_overrun), 64'd0);
        check_eq("rst.aged", 64'(o_aged), 64'd0);
        check_eq("rst.done_port", 64'(o_done_port), 64'd0);
        check_eq("rst.new_entry", 64'(o_new_entry), 64'd0);
        do_reset();

        // insert, move, refresh
        learn("learn_p2", 48'h0011_2233_4455, 3'd2, 1'b1, 1'b0);
        learn("move_p5", 48'h0011_2233_4455, 3'd5, 1'b0, 1'b0);
        learn("refresh_p5", 48'h0011_2233_4455, 3'd5, 1'b0, 1'b0);

        // both fold to index 0
        learn("idx0_first", 48'h0000_0000_0101, 3'd1, 1'b1, 1'b0);
        learn("idx0_collide", 48'h0000_0000_0202, 3'd3, 1'b0, 1'b1);
        learn("idx0_intact", 48'h0000_0000_0101, 3'd1, 1'b0, 1'b0);

        // back-to-back requests: second must be dropped with an overrun pulse
        i_SA = 48'h0000_0000_000A; i_port_num = 3'd4; i_write_en = 1'b1;
        tick();
        i_SA = 48'h0000_0000_000B; i_port_num = 3'd6;
        tick();
        i_write_en = 1'b0;
        check_eq("ovr.pulse", 64'(o_overrun), 64'd1);
        check_eq("ovr.no_done_yet", 64'(o_done), 64'd0);
        tick();
        check_eq("ovr.pulse_end", 64'(o_overrun), 64'd0);
        check_eq("ovr.first_done", 64'(o_done), 64'd1);
        check_eq("ovr.first_port", 64'(o_done_port), 64'd4);
        $display("txn overrun: first SA=00000000000a done=%0b port=%0d", o_done, o_done_port);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (o_done) cnt++;
        end
        check_eq("ovr.no_second_done", 64'(cnt), 64'd0);
        learn("ovr_dropped_sa", 48'h0000_0000_000B, 3'd6, 1'b1, 1'b0);

        // reset while the request sits in CMP
        i_SA = 48'h0000_0000_000C; i_port_num = 3'd7; i_write_en = 1'b1;
        tick();
        i_write_en = 1'b0;
        tick();
        check_eq("rstcmp.busy", 64'(o_ready), 64'd0);
        irst = 1'b1;
        #1;
        check_eq("rstcmp.ready_now", 64'(o_ready), 64'd1);
        tick();
        check_eq("rstcmp.no_done", 64'(o_done), 64'd0);
        irst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o_done) cnt++;
        end
        check_eq("rstcmp.silent", 64'(cnt), 64'd0);
        $display("txn reset_in_cmp: SA=00000000000c abandoned");
        learn("rstcmp_not_written", 48'h0000_0000_000C, 3'd7, 1'b1, 1'b0);
        learn("rstcmp_old_invalid", 48'h0011_2233_4455, 3'd2, 1'b1, 1'b0);

`ifdef AGING_EN
        // pointer passes index 5 once to set the age bit, once more to expire it (256 steps x 4 cycles apart)
        do_reset();
        learn("age_learn", 48'h0000_0000_0005, 3'd1, 1'b1, 1'b0);
        cnt = 0; first = 0;
        for (int c = 1; c <= 2500; c++) begin
            tick();
            if (o_aged) begin
                cnt++;
                if (first == 0) first = c;
            end
        end
        check_eq("age.pulses", 64'(cnt), 64'd1);
        check_eq("age.after_first_pass", 64'(first > 1000), 64'd1);
        check_eq("age.before_third_pass", 64'(first < 2100), 64'd1);
        $display("txn aging: SA=000000000005 aged after %0d cycles", first);
        learn("age_relearn", 48'h0000_0000_0005, 3'd1, 1'b1, 1'b0);
`else
        cnt = 0; first = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (o_aged) cnt++;
        end
        check_eq("noage.aged", 64'(cnt), 64'd0);
        $display("txn no_aging: idle 300 cycles, aged pulses=%0d", cnt);
        learn("noage_still_valid", 48'h0011_2233_4455, 3'd2, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
